// File: rtl/pdl_pkg.sv
// Shared sizing for the push-down-list (PDL) stack controller.
package pdl_pkg;

  localparam int PDL_AW = 10;

  // Default guard level is 16 entries below the top of the PDL.
  function automatic int pdl_guard_default(input int aw);
    return (1 << aw) - 16;
  endfunction

endpackage

// File: rtl/pdl_updown_ctr.sv
// Load/inc/dec counter for the PDL pointer. It exposes next-state and wrap events.
module pdl_updown_ctr
  import pdl_pkg::*;
#(
  parameter int AW = PDL_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] q,
  output logic [AW-1:0] nxt,
  output logic          wrap_hi,
  output logic          wrap_lo
);

  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [AW-1:0] MAX = '1;

  // Load has priority over counting. When inc and dec arrive together, they cancel.
  always_comb begin
    nxt     = q;
    wrap_hi = 1'b0;
    wrap_lo = 1'b0;
    if (load) begin
      nxt = load_val;
    end else if (inc && !dec) begin
      nxt     = q + ONE;
      wrap_hi = (q == MAX);
    end else if (dec && !inc) begin
      nxt     = q - ONE;
      wrap_lo = (q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= nxt;
  end

endmodule

// File: rtl/pdl_stack_ctl.sv
// PDL stack controller. It produces the pointer, index, RAM address, strobes, wrap flags and the high-water mark.
module pdl_stack_ctl
  import pdl_pkg::*;
#(
  parameter int AW    = PDL_AW,
  parameter int GUARD = pdl_guard_default(AW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          state_fetch,
  input  logic          state_alu,
  input  logic          state_write,
  input  logic          state_mmu,
  input  logic          state_read,
  input  logic          nop,
  input  logic          msrc_pdl,
  input  logic          srcpdltop,
  input  logic          srcpdlpop,
  input  logic          destpdltop,
  input  logic          destpdl_x,
  input  logic          destpdl_p,
  input  logic          ld_ptr,
  input  logic          ld_idx,
  input  logic [AW-1:0] ld_data,
  input  logic          clr_flags,
  output logic [AW-1:0] pdla,
  output logic [AW-1:0] pdlptr,
  output logic [AW-1:0] pdlidx,
  output logic          pdlwrite,
  output logic          pwp,
  output logic          prp,
  output logic          pdlenb,
  output logic          pdldrive,
  output logic          overflow,
  output logic          underflow,
  output logic          guard,
  output logic [AW-1:0] hwm
);

  localparam logic [AW:0]   GUARD_LVL = (AW+1)'(GUARD);
  localparam logic [AW-1:0] ONE       = AW'(1);

  logic          pwidx;
  logic          sel_ptr;
  logic          push;
  logic          pop;
  logic          wrap_hi;
  logic          wrap_lo;
  logic [AW-1:0] ptr_nxt;

  assign pdlenb   = srcpdlpop | srcpdltop;
  assign pdlwrite = destpdltop | destpdl_x | destpdl_p;
  assign prp      = pdlenb & state_read;
  assign pwp      = pdlwrite & state_write;
  assign pdldrive = pdlenb & (state_alu | state_write | state_mmu | state_fetch);

  assign push = destpdl_p;
  assign pop  = srcpdlpop & ~nop;

  pdl_updown_ctr #(.AW(AW)) u_ptr (
    .clk      (clk),
    .reset    (reset),
    .load     (state_write & ld_ptr),
    .load_val (ld_data),
    .inc      (state_write & push),
    .dec      (state_write & pop),
    .q        (pdlptr),
    .nxt      (ptr_nxt),
    .wrap_hi  (wrap_hi),
    .wrap_lo  (wrap_lo)
  );

  // A lone push pre-increments, so its write phase already addresses the new top.
  assign sel_ptr = (state_read & msrc_pdl) | (~state_read & ~pwidx);
  always_comb begin
    pdla = pdlidx;
    if (sel_ptr) pdla = (state_write & push & ~pop) ? pdlptr + ONE : pdlptr;
  end

  assign guard = {1'b0, pdlptr} >= GUARD_LVL;

  always_ff @(posedge clk) begin
    if (reset) begin
      pwidx     <= 1'b0;
      pdlidx    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      hwm       <= '0;
    end else begin
      if (state_alu | state_write) pwidx <= destpdl_x;
      if (ld_idx) pdlidx <= ld_data;
      // A wrap in the same cycle beats the clear.
      overflow  <= (overflow  & ~clr_flags) | wrap_hi;
      underflow <= (underflow & ~clr_flags) | wrap_lo;
      if (clr_flags)          hwm <= '0;
      else if (ptr_nxt > hwm) hwm <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_pdl_stack_ctl.sv
// Directed and random checks of pdl_stack_ctl against a behavioural stack model.
module tb_pdl_stack_ctl;

  localparam int AW = 10;
  localparam int D  = 1 << AW;
  localparam int GL = D - 16;

  logic clk = 1'b0;
  logic reset;
  logic state_fetch, state_alu, state_write, state_mmu, state_read;
  logic nop, msrc_pdl, srcpdltop, srcpdlpop, destpdltop, destpdl_x, destpdl_p;
  logic ld_ptr, ld_idx, clr_flags;
  logic [AW-1:0] ld_data;
  logic [AW-1:0] pdla, pdlptr, pdlidx, hwm;
  logic pdlwrite, pwp, prp, pdlenb, pdldrive, overflow, underflow, guard;

  int total = 0;
  int bad   = 0;

  int m_ptr = 0, m_idx = 0, m_hwm = 0;
  bit m_pwidx = 0, m_ov = 0, m_un = 0;
  int wr_pdla, rd_pdla;
  bit rd_prp;

  always #5 clk = ~clk;

  pdl_stack_ctl #(.AW(AW)) dut (
    .clk(clk), .reset(reset),
    .state_fetch(state_fetch), .state_alu(state_alu), .state_write(state_write),
    .state_mmu(state_mmu), .state_read(state_read),
    .nop(nop), .msrc_pdl(msrc_pdl), .srcpdltop(srcpdltop), .srcpdlpop(srcpdlpop),
    .destpdltop(destpdltop), .destpdl_x(destpdl_x), .destpdl_p(destpdl_p),
    .ld_ptr(ld_ptr), .ld_idx(ld_idx), .ld_data(ld_data), .clr_flags(clr_flags),
    .pdla(pdla), .pdlptr(pdlptr), .pdlidx(pdlidx),
    .pdlwrite(pdlwrite), .pwp(pwp), .prp(prp), .pdlenb(pdlenb), .pdldrive(pdldrive),
    .overflow(overflow), .underflow(underflow), .guard(guard), .hwm(hwm)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ph(input int p);
    {state_fetch, state_read, state_alu, state_write, state_mmu} = 5'b10000 >> p;
  endtask

  task automatic clear_ctl();
    reset = 0; nop = 0; msrc_pdl = 0; srcpdltop = 0; srcpdlpop = 0;
    destpdltop = 0; destpdl_x = 0; destpdl_p = 0;
    ld_ptr = 0; ld_idx = 0; ld_data = '0; clr_flags = 0;
  endtask

  // One clock: compare every output with the model, then advance the model.
  task automatic cyc();
    bit push, pop, sel, enb, wr;
    int e_pdla, nptr;
    bit wo, wu;
    @(negedge clk);
    push = destpdl_p;
    pop  = srcpdlpop && !nop;
    enb  = srcpdlpop || srcpdltop;
    wr   = destpdltop || destpdl_x || destpdl_p;
    sel  = (state_read && msrc_pdl) || (!state_read && !m_pwidx);
    if (!sel)                          e_pdla = m_idx;
    else if (state_write && push && !pop) e_pdla = (m_ptr + 1) % D;
    else                               e_pdla = m_ptr;
    chk("pdla", int'(pdla), e_pdla);
    chk("pdlptr", int'(pdlptr), m_ptr);
    chk("pdlidx", int'(pdlidx), m_idx);
    chk("hwm", int'(hwm), m_hwm);
    chk("overflow", int'(overflow), int'(m_ov));
    chk("underflow", int'(underflow), int'(m_un));
    chk("guard", int'(guard), int'(m_ptr >= GL));
    chk("pdlenb", int'(pdlenb), int'(enb));
    chk("pdlwrite", int'(pdlwrite), int'(wr));
    chk("prp", int'(prp), int'(enb && state_read));
    chk("pwp", int'(pwp), int'(wr && state_write));
    chk("pdldrive", int'(pdldrive), int'(enb && !state_read));
    if (state_write) wr_pdla = int'(pdla);
    if (state_read) begin rd_pdla = int'(pdla); rd_prp = prp; end
    @(posedge clk);
    if (reset) begin
      m_ptr = 0; m_idx = 0; m_hwm = 0; m_pwidx = 0; m_ov = 0; m_un = 0;
    end else begin
      nptr = m_ptr; wo = 0; wu = 0;
      if (state_write) begin
        if (ld_ptr) nptr = int'(ld_data);
        else if (push && !pop) begin wo = (m_ptr == D-1); nptr = (m_ptr + 1) % D; end
        else if (pop && !push) begin wu = (m_ptr == 0);   nptr = (m_ptr + D - 1) % D; end
      end
      if (state_alu || state_write) m_pwidx = destpdl_x;
      if (ld_idx) m_idx = int'(ld_data);
      if (clr_flags) begin m_ov = 0; m_un = 0; m_hwm = 0; end
      else if (nptr > m_hwm) m_hwm = nptr;
      m_ov = m_ov | wo;
      m_un = m_un | wu;
      m_ptr = nptr;
    end
    #1;
  endtask

  // One instruction: fetch, read, alu, write, mmu with the controls held.
  task automatic instr(input bit push, input bit pop, input bit nopv, input bit x,
                       input bit msrc, input bit ldp, input int ld);
    clear_ctl();
    destpdl_p = push; srcpdlpop = pop; nop = nopv; destpdl_x = x;
    msrc_pdl = msrc; ld_ptr = ldp; ld_data = AW'(ld);
    for (int p = 0; p < 5; p++) begin
      set_ph(p);
      cyc();
    end
    clear_ctl();
  endtask

  initial begin
    clear_ctl();
    set_ph(0);
    reset = 1;
    @(posedge clk); #1;
    cyc();
    reset = 0;
    chk("rst_ptr", int'(pdlptr), 0);
    chk("rst_hwm", int'(hwm), 0);

    // Three pushes from empty.
    for (int i = 1; i <= 3; i++) begin
      instr(1, 0, 0, 0, 0, 0, 0);
      chk("push_wr_pdla", wr_pdla, i);
      chk("push_ptr", int'(pdlptr), i);
    end
    chk("push_hwm", int'(hwm), 3);

    // Pop, then a squashed pop.
    instr(0, 1, 0, 0, 1, 0, 0);
    chk("pop_ptr", int'(pdlptr), 2);
    chk("pop_prp", int'(rd_prp), 1);
    instr(0, 1, 1, 0, 1, 0, 0);
    chk("nop_ptr", int'(pdlptr), 2);
    chk("nop_prp", int'(rd_prp), 1);

    // Wrap both ways, then clear.
    instr(0, 0, 0, 0, 0, 1, 0);
    instr(0, 1, 0, 0, 0, 0, 0);
    chk("uf_ptr", int'(pdlptr), D-1);
    chk("uf_flag", int'(underflow), 1);
    instr(1, 0, 0, 0, 0, 0, 0);
    chk("of_ptr", int'(pdlptr), 0);
    chk("of_flag", int'(overflow), 1);
    clr_flags = 1; set_ph(0); cyc(); clr_flags = 0;
    chk("clr_of", int'(overflow), 0);
    chk("clr_uf", int'(underflow), 0);
    chk("clr_hwm", int'(hwm), 0);

    // Push and pop in the same instruction.
    instr(0, 0, 0, 0, 0, 1, 5);
    instr(1, 1, 0, 0, 1, 0, 0);
    chk("pp_rd_pdla", rd_pdla, 5);
    chk("pp_wr_pdla", wr_pdla, 5);
    chk("pp_ptr", int'(pdlptr), 5);

    // Indexed write, then a pointer load with push.
    ld_idx = 1; ld_data = 10'h040; set_ph(0); cyc(); clear_ctl();
    instr(0, 0, 0, 1, 0, 0, 0);
    chk("idx_wr_pdla", wr_pdla, 'h40);
    instr(1, 0, 0, 0, 0, 1, 'h3F0);
    chk("ldp_ptr", int'(pdlptr), 'h3F0);
    chk("ldp_guard", int'(guard), 1);

    // A reset during the write phase of a wrapping push.
    instr(0, 0, 0, 0, 0, 1, D-1);
    destpdl_p = 1; set_ph(3); reset = 1; cyc(); clear_ctl();
    chk("rstw_ptr", int'(pdlptr), 0);
    chk("rstw_of", int'(overflow), 0);
    chk("rstw_hwm", int'(hwm), 0);

    // Random phases and controls.
    for (int n = 0; n < 600; n++) begin
      set_ph($urandom_range(0, 4));
      reset      = ($urandom_range(0, 49) == 0);
      clr_flags  = ($urandom_range(0, 19) == 0);
      nop        = ($urandom_range(0, 3) == 0);
      msrc_pdl   = $urandom_range(0, 1);
      srcpdltop  = ($urandom_range(0, 3) == 0);
      srcpdlpop  = ($urandom_range(0, 2) == 0);
      destpdltop = ($urandom_range(0, 3) == 0);
      destpdl_x  = ($urandom_range(0, 3) == 0);
      destpdl_p  = ($urandom_range(0, 2) == 0);
      ld_ptr     = ($urandom_range(0, 11) == 0);
      ld_idx     = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       ld_data = '0;
        1:       ld_data = '1;
        2:       ld_data = AW'(GL - 1);
        default: ld_data = AW'($urandom);
      endcase
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pdl_stack_ctl.md
PDL_STACK_CTL -- requirements
Module: pdl_stack_ctl

Interface
REQ-001 Parameter AW, default 10: PDL address width; depth = 2**AW entries.
REQ-002 Parameter GUARD, default 2**AW-16: pointer level at or above which guard asserts.
REQ-003 The clock is clk; reset is synchronous and active-high, named reset.
REQ-004 clk  in  1  clock.
REQ-005 reset  in  1  synchronous reset, active-high.
REQ-006 state_fetch, state_alu, state_write, state_mmu, state_read  in  1 each  one-hot machine phases.
REQ-007 nop  in  1  squash current instruction's pop.
REQ-008 msrc_pdl  in  1  M-source addresses PDL via pointer (IR bit 30).
REQ-009 srcpdltop, srcpdlpop  in  1 each  PDL read: top / top-and-pop.
REQ-010 destpdltop, destpdl_x, destpdl_p  in  1 each  PDL write: top / indexed / push.
REQ-011 ld_ptr, ld_idx  in  1 each  load pointer / index from ld_data.
REQ-012 ld_data  in  AW  load value.
REQ-013 clr_flags  in  1  clear sticky flags and high-water mark.
REQ-014 pdla  out  AW  PDL RAM address.
REQ-015 pdlptr, pdlidx  out  AW each  pointer and index registers.
REQ-016 pdlwrite, pwp, prp, pdlenb, pdldrive  out  1 each  write request, write pulse, read pulse, read enable, bus drive.
REQ-017 overflow, underflow  out  1 each  sticky wrap flags.
REQ-018 guard  out  1  pdlptr >= GUARD.
REQ-019 hwm  out  AW  highest pdlptr value since last clear.

Function
REQ-020 pdlenb = srcpdlpop | srcpdltop; pdlwrite = destpdltop | destpdl_x | destpdl_p.
REQ-021 prp = pdlenb & state_read; pwp = pdlwrite & state_write.
REQ-022 pdldrive = pdlenb & (state_alu | state_write | state_mmu | state_fetch).
REQ-023 pwidx register: loads destpdl_x on any clock where state_alu | state_write; otherwise holds.
REQ-024 Pointer-select = (state_read & msrc_pdl) | (~state_read & ~pwidx); pdla = pdlidx when select is 0.
REQ-025 When select is 1: pdla = pdlptr+1 (mod 2**AW) during state_write if destpdl_p & ~(srcpdlpop & ~nop); pdlptr otherwise.
REQ-026 Pointer update occurs only on the clock edge ending state_write; all other phases hold pdlptr.
REQ-027 Push alone (destpdl_p): pdlptr <= pdlptr+1 (pre-increment).
REQ-028 Pop alone (srcpdlpop & ~nop): pdlptr <= pdlptr-1 after the read.
REQ-029 Push and pop together: pdlptr unchanged; write replaces top at pdlptr.
REQ-030 nop suppresses pop only; push is never suppressed.
REQ-031 Push at pdlptr = 2**AW-1 wraps to 0 and sets overflow.
REQ-032 Pop at pdlptr = 0 wraps to 2**AW-1 and sets underflow.
REQ-033 ld_ptr during state_write: pdlptr <= ld_data, overriding push/pop; no flag change. ld_idx: pdlidx <= ld_data, any phase.
REQ-034 hwm <= max(hwm, next pdlptr) every clock.
REQ-035 clr_flags zeroes overflow, underflow and hwm; a same-cycle wrap event wins, setting its flag.
REQ-036 guard is combinational from pdlptr, zero latency.

Reset
REQ-037 reset, overriding all other inputs, clears pdlptr, pdlidx, pwidx, overflow, underflow and hwm to 0; combinational outputs follow from those values.

Structure
REQ-038 Shared package pdl_pkg holds default AW and the GUARD default expression.
REQ-039 Sub-module pdl_updown_ctr (AW-bit load/inc/dec counter with wrap outputs) implements pdlptr.

Verification
REQ-040 Reset, then push 3 times (destpdl_p through write phase) -> pdlptr 1,2,3; write pdla 1,2,3; hwm 3.
REQ-041 pdlptr=3, srcpdlpop with nop=0 then nop=1 -> pdlptr 2, then stays 2; prp pulses in both state_read phases.
REQ-042 pdlptr=0 pop -> pdlptr 1023, underflow=1; pdlptr=1023 push -> 0, overflow=1; clr_flags -> both 0, hwm 0.
REQ-043 Same-instruction push+pop at pdlptr=5 -> pdla 5 in read and write, pdlptr stays 5.
REQ-044 destpdl_x with pdlidx=0x40 -> next phase pwidx=1, pdla=0x40; ld_ptr 0x3F0 with push -> pdlptr 0x3F0, guard=1.
REQ-045 Assert reset mid-push during state_write -> all registers 0 next clock, no flag set.
